// File: rtl/button_gesture.sv
// Per-button gesture classifier: turns debounced press/release edges into one-cycle
// click, double-click, long-press and hold-repeat pulses.
module button_gesture #(
    parameter int unsigned LONG_TICKS   = 12000000,
    parameter int unsigned GAP_TICKS    = 3000000,
    parameter int unsigned REPEAT_TICKS = 6000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    input  logic btn_rise,
    input  logic btn_fall,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic hold_repeat,
    output logic busy
);

    localparam int unsigned MaxLg    = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
    localparam int unsigned MaxTicks = (MaxLg > REPEAT_TICKS) ? MaxLg : REPEAT_TICKS;
    localparam int unsigned CntW     = $clog2(MaxTicks + 1);
    localparam bit          RepEn    = (REPEAT_TICKS != 0);

    localparam logic [CntW-1:0] LongTerm = CntW'(LONG_TICKS - 1);
    localparam logic [CntW-1:0] GapTerm  = CntW'(GAP_TICKS - 1);
    localparam logic [CntW-1:0] RepTerm  = CntW'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
    localparam logic [CntW-1:0] CntMax   = '1;

    typedef enum logic [2:0] {
        StIdle,
        StPress1,
        StWait2,
        StLong,
        StIgnore
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            click_q, click_d;
    logic            dbl_q, dbl_d;
    logic            long_q, long_d;
    logic            rep_q, rep_d;
    logic            rise, fall, timed;

    // Coincident rise and fall cancel each other out.
    assign rise = btn_rise & ~btn_fall;
    assign fall = btn_fall & ~btn_rise;

    always_comb begin
        state_d = state_q;
        click_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPress1;
                end else if (btn_level) begin
                    state_d = StIgnore;
                end
            end
            StPress1: begin
                if (fall) begin
                    state_d = StWait2;
                end else if (cnt_q == LongTerm) begin
                    state_d = StLong;
                    long_d  = 1'b1;
                end
            end
            StWait2: begin
                if (rise) begin
                    state_d = StIgnore;
                    dbl_d   = 1'b1;
                end else if (cnt_q == GapTerm) begin
                    state_d = StIdle;
                    click_d = 1'b1;
                end
            end
            StLong: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (RepEn && (cnt_q == RepTerm)) begin
                    rep_d = 1'b1;
                end
            end
            StIgnore: begin
                if (fall || !btn_level) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter restarts on any state change or repeat; saturates so LONG without repeat never wraps.
    always_comb begin
        timed = (state_q == StPress1) || (state_q == StWait2) || (state_q == StLong);
        cnt_d = cnt_q;
        if ((state_d != state_q) || rep_d || !timed) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            click_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            click_q <= click_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
        end
    end

    assign click        = click_q;
    assign double_click = dbl_q;
    assign long_press   = long_q;
    assign hold_repeat  = rep_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture: timing scenarios, reset corner cases and a randomized run
// against a timestamp-based gesture model, on a repeat-enabled and a repeat-disabled build.
module tb_button_gesture;

    localparam int LONG = 8;
    localparam int GAP  = 4;
    localparam int REP  = 3;

    logic clk;
    logic rst_n;
    logic btn_level, btn_rise, btn_fall;
    logic click_a, dbl_a, long_a, rep_a, busy_a;
    logic click_b, dbl_b, long_b, rep_b, busy_b;
    logic [4:0] out_a, out_b;

    int n_chk = 0;
    int n_err = 0;

    button_gesture #(
        .LONG_TICKS  (LONG),
        .GAP_TICKS   (GAP),
        .REPEAT_TICKS(REP)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_level   (btn_level),
        .btn_rise    (btn_rise),
        .btn_fall    (btn_fall),
        .click       (click_a),
        .double_click(dbl_a),
        .long_press  (long_a),
        .hold_repeat (rep_a),
        .busy        (busy_a)
    );

    button_gesture #(
        .LONG_TICKS  (LONG),
        .GAP_TICKS   (GAP),
        .REPEAT_TICKS(0)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_level   (btn_level),
        .btn_rise    (btn_rise),
        .btn_fall    (btn_fall),
        .click       (click_b),
        .double_click(dbl_b),
        .long_press  (long_b),
        .hold_repeat (rep_b),
        .busy        (busy_b)
    );

    // Bit order everywhere: {click, double_click, long_press, repeat, busy}
    assign out_a = {click_a, dbl_a, long_a, rep_a, busy_a};
    assign out_b = {click_b, dbl_b, long_b, rep_b, busy_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model: gesture tracked by timestamps ----------------
    typedef struct {
        int         held_since;
        int         released_at;
        int         long_at;
        bit         ignoring;
        logic [4:0] out;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.held_since  = -1;
        m.released_at = -1;
        m.long_at     = -1;
        m.ignoring    = 1'b0;
        m.out         = '0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t mi, input int n, input bit rin, input bit fin,
                                      input bit lvl, input int rep);
        mdl_t m;
        bit r, f, c, d, lp, rp, bz;
        m  = mi;
        r  = rin && !fin;
        f  = fin && !rin;
        c  = 1'b0;
        d  = 1'b0;
        lp = 1'b0;
        rp = 1'b0;
        if (m.ignoring) begin
            if (f || !lvl) m.ignoring = 1'b0;
        end else if (m.long_at >= 0) begin
            if (f) m.long_at = -1;
            else if (rep != 0 && ((n - m.long_at) % rep) == 0) rp = 1'b1;
        end else if (m.released_at >= 0) begin
            if (r) begin
                d = 1'b1;
                m.released_at = -1;
                m.ignoring = 1'b1;
            end else if (n - m.released_at == GAP) begin
                c = 1'b1;
                m.released_at = -1;
            end
        end else if (m.held_since >= 0) begin
            if (f) begin
                m.released_at = n;
                m.held_since = -1;
            end else if (n - m.held_since == LONG) begin
                lp = 1'b1;
                m.long_at = n;
                m.held_since = -1;
            end
        end else if (r) begin
            m.held_since = n;
        end else if (lvl) begin
            m.ignoring = 1'b1;
        end
        bz = (m.held_since >= 0) || (m.released_at >= 0) || (m.long_at >= 0) || m.ignoring;
        m.out = {c, d, lp, rp, bz};
        return m;
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [63:0] bitm(input int k);
        logic [63:0] v;
        v = 64'd1;
        return v << k;
    endfunction

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] v;
        v = '0;
        for (int k = lo; k <= hi; k++) v[k] = 1'b1;
        return v;
    endfunction

    task automatic drive_edge(input bit r, input bit f, input bit l);
        btn_rise  = r;
        btn_fall  = f;
        btn_level = l;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        btn_rise  = 1'b0;
        btn_fall  = 1'b0;
        btn_level = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_a", out_a, 5'b00000);
        check("reset_b", out_b, 5'b00000);
        rst_n = 1'b1;
    endtask

    // ---------------- table-driven timing scenarios ----------------
    typedef struct {
        string       name;
        int          r1, f1, r2, f2, both;
        logic [63:0] mc, md, ml, mr, mb;
    } scn_t;

    scn_t scns[8];

    task automatic run_scn(input scn_t s);
        logic [63:0] ga[5];
        logic [63:0] gb[5];
        logic [63:0] want[5];
        string       nm[5];
        bit          lvl;
        for (int j = 0; j < 5; j++) begin
            ga[j] = '0;
            gb[j] = '0;
        end
        do_reset();
        for (int n = 0; n < 40; n++) begin
            lvl = (s.r1 >= 0 && n >= s.r1 && (s.f1 < 0 || n < s.f1)) ||
                  (s.r2 >= 0 && n >= s.r2 && (s.f2 < 0 || n < s.f2));
            drive_edge((n == s.r1) || (n == s.r2) || (n == s.both),
                       (n == s.f1) || (n == s.f2) || (n == s.both), lvl);
            for (int j = 0; j < 5; j++) begin
                ga[j][n+1] = out_a[4-j];
                gb[j][n+1] = out_b[4-j];
            end
        end
        want = '{s.mc, s.md, s.ml, s.mr, s.mb};
        nm   = '{"click", "double", "long", "repeat", "busy"};
        for (int j = 0; j < 5; j++) begin
            check($sformatf("%s/%s/rep3", s.name, nm[j]), ga[j], want[j]);
            check($sformatf("%s/%s/rep0", s.name, nm[j]), gb[j], (j == 3) ? 64'd0 : want[j]);
        end
    endtask

    // ---------------- hand-written reset sequences ----------------
    task automatic seq_held();
        rst_n     = 1'b0;
        btn_rise  = 1'b0;
        btn_fall  = 1'b0;
        btn_level = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive_edge(1'b0, 1'b0, 1'b1);
            check("held/a", out_a, 5'b00001);
            check("held/b", out_b, 5'b00001);
        end
        drive_edge(1'b0, 1'b1, 1'b0);
        check("held_release/a", out_a, 5'b00000);
        check("held_release/b", out_b, 5'b00000);
    endtask

    task automatic seq_press1_reset();
        do_reset();
        drive_edge(1'b1, 1'b0, 1'b1);
        check("press1_busy", out_a, 5'b00001);
        drive_edge(1'b0, 1'b0, 1'b1);
        drive_edge(1'b0, 1'b0, 1'b1);
        rst_n     = 1'b0;
        btn_level = 1'b0;
        #1;
        check("press1_rst_async/a", out_a, 5'b00000);
        check("press1_rst_async/b", out_b, 5'b00000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            drive_edge(1'b0, 1'b0, 1'b0);
            check("press1_after_rst", out_a, 5'b00000);
        end
    endtask

    task automatic seq_long_reset();
        do_reset();
        drive_edge(1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= LONG; k++) drive_edge(1'b0, 1'b0, 1'b1);
        check("long_pulse/a", out_a, 5'b00101);
        check("long_pulse/b", out_b, 5'b00101);
        rst_n = 1'b0;
        #1;
        check("long_rst_async/a", out_a, 5'b00000);
        check("long_rst_async/b", out_b, 5'b00000);
        btn_level = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_edge(1'b0, 1'b0, 1'b0);
            check("long_after_rst", out_a, 5'b00000);
        end
    endtask

    task automatic seq_wait2_reset();
        do_reset();
        drive_edge(1'b1, 1'b0, 1'b1);
        drive_edge(1'b0, 1'b0, 1'b1);
        drive_edge(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drive_edge(1'b0, 1'b0, 1'b0);
        check("wait2_busy", out_a, 5'b00001);
        rst_n = 1'b0;
        #1;
        check("wait2_rst_async/a", out_a, 5'b00000);
        check("wait2_rst_async/b", out_b, 5'b00000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_edge(1'b0, 1'b0, 1'b0);
            check("wait2_after_rst", out_a, 5'b00000);
        end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic run_random(input int cycles);
        mdl_t ma, mb;
        bit   lvl, r, f;
        int   dur, cyc;
        do_reset();
        ma  = mdl_reset();
        mb  = mdl_reset();
        lvl = 1'b0;
        dur = 3;
        cyc = 0;
        for (int i = 0; i < cycles; i++) begin
            r     = 1'b0;
            f     = 1'b0;
            rst_n = ($urandom_range(0, 299) != 0);
            if (dur == 0) begin
                lvl = !lvl;
                // Rarely drop the edge pulse to mimic a missed press/release.
                if ($urandom_range(0, 59) != 0) begin
                    r = lvl;
                    f = !lvl;
                end
                dur = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 22) : $urandom_range(1, 9);
            end else begin
                dur--;
                if ($urandom_range(0, 49) == 0) begin
                    r = 1'b1;
                    f = 1'b1;
                end
            end
            btn_rise  = r;
            btn_fall  = f;
            btn_level = lvl;
            @(posedge clk);
            if (!rst_n) begin
                ma = mdl_reset();
                mb = mdl_reset();
            end else begin
                ma = mdl_step(ma, cyc, r, f, lvl, REP);
                mb = mdl_step(mb, cyc, r, f, lvl, 0);
            end
            cyc++;
            #1;
            check($sformatf("rand/rep3/cyc%0d", cyc), out_a, ma.out);
            check($sformatf("rand/rep0/cyc%0d", cyc), out_b, mb.out);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_level = 1'b0;
        btn_rise  = 1'b0;
        btn_fall  = 1'b0;

        scns[0] = '{"single", 10, 13, -1, -1, -1, bitm(18), 64'd0, 64'd0, 64'd0, span(11, 17)};
        scns[1] = '{"double", 10, 12, 14, 16, -1, 64'd0, bitm(15), 64'd0, 64'd0, span(11, 16)};
        scns[2] = '{"long_repeat", 10, 30, -1, -1, -1, 64'd0, 64'd0, bitm(19),
                    bitm(22) | bitm(25) | bitm(28), span(11, 30)};
        scns[3] = '{"fall_at_long_term", 10, 18, -1, -1, -1, bitm(23), 64'd0, 64'd0, 64'd0,
                    span(11, 22)};
        scns[4] = '{"fall_after_long", 10, 19, -1, -1, -1, 64'd0, 64'd0, bitm(19), 64'd0,
                    span(11, 19)};
        scns[5] = '{"rise_at_gap_term", 10, 12, 16, 18, -1, 64'd0, bitm(17), 64'd0, 64'd0,
                    span(11, 18)};
        scns[6] = '{"rise_after_gap", 10, 12, 17, 18, -1, bitm(17) | bitm(23), 64'd0, 64'd0,
                    64'd0, span(11, 16) | span(18, 22)};
        scns[7] = '{"rise_fall_idle", -1, -1, -1, -1, 10, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};

        for (int i = 0; i < 8; i++) run_scn(scns[i]);

        seq_held();
        seq_press1_reset();
        seq_long_reset();
        seq_wait2_reset();
        run_random(3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
